pwm_capture_16bits: RTL and testbench
=====================================

Name: pwm_capture_16bits

Overview:
- Receive-side companion to the carrier-based PWM generator: measures a complementary PWM pair (A/B) arriving from pins or from a generator output loopback.
- Per carrier period it reports: period, high time of A and B, and both dead times.
- Flags shoot-through overlap and loss of signal, and raises an interrupt on each completed measurement.
- Used for closed-loop self-test of the PWM outputs and for capturing externally generated gating signals.

Parameters:
- CNT_WIDTH, 16, width of all measurement counters and result registers (matches PWM counter width).
- SYNC_STAGES, 2, synchronizer flops on each PWM input (minimum 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- capture_onoff  in  1  1 = capture enabled; 0 = forces IDLE.
- int_onoff  in  1  1 = interrupt enabled.
- pwm_A_in  in  1  asynchronous PWM leg A.
- pwm_B_in  in  1  asynchronous PWM leg B.
- timeout_limit  in  CNT_WIDTH  loss-of-signal limit in clk cycles; 0 disables timeout.
- clear_flags  in  1  single-cycle pulse; clears overlap_err and timeout_err.
- period_A  out  CNT_WIDTH  clk cycles between consecutive A rising edges.
- high_A  out  CNT_WIDTH  A high time within that period.
- high_B  out  CNT_WIDTH  B high time within that period.
- dtime_AB  out  CNT_WIDTH  cycles from A falling edge to the next B rising edge.
- dtime_BA  out  CNT_WIDTH  cycles from B falling edge to the next A rising edge.
- meas_valid  out  1  one-cycle pulse; all five results updated together.
- overlap_err  out  1  sticky; synchronized A and B were high in the same cycle.
- timeout_err  out  1  sticky; no A rising edge within timeout_limit cycles.
- interrupt  out  1  one-cycle pulse.

Behaviour:
- Reset, or capture_onoff = 0:
  - All outputs go to 0. Counters clear. State = IDLE.
  - Synchronizer flops clear to 0.
  - Sticky flags clear on reset only. capture_onoff = 0 does not clear them.
- Inputs pass through SYNC_STAGES flops plus one edge-detect register. Every measurement uses the synchronized signals, so this latency cancels out of all results.
- States:
  - IDLE -> ARM when capture_onoff = 1.
  - ARM: waits for the first synchronized A rising edge. That edge starts the counters and moves the FSM to MEASURE. No result is produced.
  - MEASURE: each A rising edge closes the period, latches results, and restarts the counters.
  - MEASURE -> ARM on timeout.
  - Any state -> IDLE when capture_onoff = 0, at the same cycle boundary.
- Period counter:
  - Loads 1 in the cycle after an A rising edge, then increments each cycle.
  - At the next rising edge, period_A = counter value. A 2000-cycle period reads 2000.
- high_A / high_B counters: increment on each cycle the synchronized leg is 1 within the current period.
- dtime_AB:
  - Counts from the cycle after A falls until the cycle B is first seen rising; latched at that B rise.
  - Reads 0 if B is already high when A falls, or if no B rise occurs in the period.
- dtime_BA:
  - Counts from B falling until the A rising edge that closes the period.
  - Reads 0 if B is still high at that A rising edge.
- Arithmetic: all counters saturate at all-ones, with no wrap. A saturated period is reported as all-ones.
- meas_valid:
  - Asserted the cycle after each A rising edge in MEASURE.
  - Results are registered in the same cycle and hold until the next meas_valid.
- Overlap: synchronized A & B = 1 in any cycle of ARM or MEASURE sets overlap_err the next cycle.
- Timeout (timeout_limit != 0):
  - When the period counter reaches timeout_limit in MEASURE, or ARM has idled that long, timeout_err sets the next cycle and the FSM returns to ARM.
  - No meas_valid is issued and results hold their old values.
- interrupt = int_onoff & (meas_valid | timeout_err rising), registered, one cycle.
- Simultaneous events:
  - clear_flags with a same-cycle set condition: set wins.
  - A rising edge in the same cycle the timeout is reached: the edge wins, the period is reported, and no timeout is raised.
  - Synchronized A and B edges in the same cycle: both edges are processed.
- Minimum measurable high or low time: 1 cycle. Pulses shorter than a clk period may be missed.

Test Plan:
- Period 2000 cycles: A high 500, B rises 10 after A falls, B high 1480 -> from the second period onward each meas_valid reports period_A=2000, high_A=500, high_B=1480, dtime_AB=10, dtime_BA=10. No flags set. interrupt pulses when int_onoff=1.
- Same stimulus after reset -> the first A edge only arms, and the first meas_valid appears about 2000 cycles later. With int_onoff=0, interrupt stays 0.
- A and B overlap for 5 cycles -> overlap_err=1 and dtime_AB=0. clear_flags then clears the flag. clear_flags coincident with a new overlap keeps it 1.
- timeout_limit=3000, A stuck low after one period -> timeout_err sets 3000 cycles after the last edge and interrupt pulses once. Restarting a 1000-cycle PWM gives period_A=1000 at the second edge.
- timeout_limit=0, A period 70000 -> period_A=16'hFFFF and high counts saturate. No timeout is raised.
- capture_onoff dropped mid-period, then raised -> all outputs are 0 and the FSM re-arms. The first report is a full clean period. Sticky flags survive the drop.

Source files
------------

// File: rtl/pwm_capture_16bits_if.sv
// Signal bundle for the PWM capture block: control inputs, the two PWM legs,
// and the measurement results and status flags.
interface pwm_capture_16bits_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 capture_onoff;
  logic                 int_onoff;
  logic                 pwm_A_in;
  logic                 pwm_B_in;
  logic [CNT_WIDTH-1:0] timeout_limit;
  logic                 clear_flags;
  logic [CNT_WIDTH-1:0] period_A;
  logic [CNT_WIDTH-1:0] high_A;
  logic [CNT_WIDTH-1:0] high_B;
  logic [CNT_WIDTH-1:0] dtime_AB;
  logic [CNT_WIDTH-1:0] dtime_BA;
  logic                 meas_valid;
  logic                 overlap_err;
  logic                 timeout_err;
  logic                 interrupt;

  modport master (
    output capture_onoff, int_onoff, pwm_A_in, pwm_B_in, timeout_limit, clear_flags,
    input  period_A, high_A, high_B, dtime_AB, dtime_BA,
    input  meas_valid, overlap_err, timeout_err, interrupt
  );

  modport slave (
    input  capture_onoff, int_onoff, pwm_A_in, pwm_B_in, timeout_limit, clear_flags,
    output period_A, high_A, high_B, dtime_AB, dtime_BA,
    output meas_valid, overlap_err, timeout_err, interrupt
  );
endinterface

// File: rtl/pwm_capture_16bits.sv
// Complementary PWM pair capture: per A period reports period, high times of
// both legs and both dead times; flags overlap and loss of signal.
module pwm_capture_16bits #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                reset,
  pwm_capture_16bits_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic [SYNC_STAGES:0]   vpipe;
  logic                   a_d, b_d;
  logic                   a_s, b_s, sample_ok;
  logic                   rise_a, fall_a, rise_b, fall_b;

  logic                   close, arm_start, start, timeout_hit, to_reached;
  logic                   overlap_set;

  logic [CNT_WIDTH-1:0]   cnt, high_a_cnt, high_b_cnt, ab_cnt, ab_lat, ba_cnt;
  logic                   ab_active, ba_active;

  assign a_s = sync_a[SYNC_STAGES-1];
  assign b_s = sync_b[SYNC_STAGES-1];
  // vpipe tracks how far real samples have propagated after a clear, so the
  // zeroed synchronizer cannot fake an edge when capture is re-enabled.
  assign sample_ok = vpipe[SYNC_STAGES];
  assign rise_a = sample_ok &  a_s & ~a_d;
  assign fall_a = sample_ok & ~a_s &  a_d;
  assign rise_b = sample_ok &  b_s & ~b_d;
  assign fall_b = sample_ok & ~b_s &  b_d;
  assign start  = arm_start | close;
  assign overlap_set = bus.capture_onoff & (state != IDLE) & a_s & b_s;

  // Input synchronizers and edge-detect registers.
  always_ff @(posedge clk) begin
    if (reset || !bus.capture_onoff) begin
      sync_a <= '0;
      sync_b <= '0;
      vpipe  <= '0;
      a_d    <= 1'b0;
      b_d    <= 1'b0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], bus.pwm_A_in};
      sync_b <= {sync_b[SYNC_STAGES-2:0], bus.pwm_B_in};
      vpipe  <= {vpipe[SYNC_STAGES-1:0], 1'b1};
      a_d    <= a_s;
      b_d    <= b_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, period close, arming and timeout decisions.
  always_comb begin
    state_next  = state;
    close       = 1'b0;
    arm_start   = 1'b0;
    timeout_hit = 1'b0;
    to_reached  = (bus.timeout_limit != '0) && (cnt >= bus.timeout_limit);
    if (!bus.capture_onoff) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_next = ARM;
        ARM: begin
          if (rise_a) begin
            arm_start  = 1'b1;
            state_next = MEASURE;
          end else if (to_reached) begin
            timeout_hit = 1'b1;
          end
        end
        MEASURE: begin
          if (rise_a) begin
            close = 1'b1;
          end else if (to_reached) begin
            timeout_hit = 1'b1;
            state_next  = ARM;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Measurement counters, result registers, meas_valid and interrupt.
  always_ff @(posedge clk) begin
    if (reset || !bus.capture_onoff) begin
      cnt           <= '0;
      high_a_cnt    <= '0;
      high_b_cnt    <= '0;
      ab_cnt        <= '0;
      ab_lat        <= '0;
      ab_active     <= 1'b0;
      ba_cnt        <= '0;
      ba_active     <= 1'b0;
      bus.period_A  <= '0;
      bus.high_A    <= '0;
      bus.high_B    <= '0;
      bus.dtime_AB  <= '0;
      bus.dtime_BA  <= '0;
      bus.meas_valid <= 1'b0;
      bus.interrupt <= 1'b0;
    end else begin
      bus.meas_valid <= close;
      bus.interrupt  <= bus.int_onoff & (close | (timeout_hit & ~bus.timeout_err));

      if (start)                           cnt <= ONE;
      else if (timeout_hit || state == IDLE) cnt <= '0;
      else                                 cnt <= sat_inc(cnt);

      // The edge cycle itself belongs to the new period, so loads count it.
      if (start) begin
        high_a_cnt <= ONE;
        high_b_cnt <= b_s ? ONE : '0;
      end else begin
        if (a_s) high_a_cnt <= sat_inc(high_a_cnt);
        if (b_s) high_b_cnt <= sat_inc(high_b_cnt);
      end

      if (start) begin
        ab_active <= 1'b0;
        ab_lat    <= '0;
        ab_cnt    <= '0;
      end else if (fall_a) begin
        ab_active <= ~b_s;
        ab_cnt    <= ONE;
      end else if (ab_active) begin
        if (rise_b) begin
          ab_lat    <= ab_cnt;
          ab_active <= 1'b0;
        end else begin
          ab_cnt <= sat_inc(ab_cnt);
        end
      end

      if (fall_b) begin
        ba_active <= 1'b1;
        ba_cnt    <= ONE;
      end else if (rise_a || rise_b) begin
        ba_active <= 1'b0;
      end else if (ba_active) begin
        ba_cnt <= sat_inc(ba_cnt);
      end

      if (close) begin
        bus.period_A <= cnt;
        bus.high_A   <= high_a_cnt;
        bus.high_B   <= high_b_cnt;
        bus.dtime_AB <= (ab_active && rise_b) ? ab_cnt : ab_lat;
        bus.dtime_BA <= (ba_active && !b_s) ? ba_cnt : '0;
      end
    end
  end

  // Sticky error flags; a same-cycle set beats clear_flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.overlap_err <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      if (overlap_set)          bus.overlap_err <= 1'b1;
      else if (bus.clear_flags) bus.overlap_err <= 1'b0;
      if (timeout_hit)          bus.timeout_err <= 1'b1;
      else if (bus.clear_flags) bus.timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_capture_16bits.sv
// Directed bench for pwm_capture_16bits: a 16-bit instance for the main
// scenarios and an 8-bit instance for counter saturation.
module tb_pwm_capture_16bits;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pwm_capture_16bits_if #(.CNT_WIDTH(16)) bus ();
  pwm_capture_16bits_if #(.CNT_WIDTH(8))  bus8 ();

  pwm_capture_16bits #(.CNT_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  pwm_capture_16bits #(.CNT_WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int mv_cnt = 0;
  int int_cnt = 0;
  int first_mv_delta = -1;
  int cap_period, cap_high_a, cap_high_b, cap_ab, cap_ba;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every measurement report and interrupt pulse of the 16-bit DUT.
  always @(negedge clk) begin
    if (bus.meas_valid === 1'b1) begin
      if (mv_cnt == 0) first_mv_delta = cyc - last_rise_cyc;
      mv_cnt++;
      cap_period = int'(bus.period_A);
      cap_high_a = int'(bus.high_A);
      cap_high_b = int'(bus.high_B);
      cap_ab     = int'(bus.dtime_AB);
      cap_ba     = int'(bus.dtime_BA);
    end
    if (bus.interrupt === 1'b1) int_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives n cycles of a PWM pair starting at phase 'start' of the period.
  task automatic drive(input int sel, input int per, input int a_hi, input int b_rise,
                       input int b_hi, input int start, input int n);
    int ph;
    logic a, b;
    for (int i = 0; i < n; i++) begin
      ph = (start + i) % per;
      a  = (ph < a_hi);
      b  = (ph >= b_rise) && (ph < b_rise + b_hi);
      @(negedge clk);
      if (sel == 0) begin
        if (a && !bus.pwm_A_in) last_rise_cyc = cyc;
        bus.pwm_A_in = a;
        bus.pwm_B_in = b;
      end else begin
        bus8.pwm_A_in = a;
        bus8.pwm_B_in = b;
      end
    end
  endtask

  task automatic check_caps(input string tag, input int p, input int ha, input int hb,
                            input int ab, input int ba);
    check({tag, "_period"}, cap_period, p);
    check({tag, "_high_A"}, cap_high_a, ha);
    check({tag, "_high_B"}, cap_high_b, hb);
    check({tag, "_dtime_AB"}, cap_ab, ab);
    check({tag, "_dtime_BA"}, cap_ba, ba);
  endtask

  initial begin
    int mv0, int0;
    logic found;

    reset = 1'b1;
    bus.capture_onoff = 1'b0;  bus8.capture_onoff = 1'b0;
    bus.int_onoff     = 1'b0;  bus8.int_onoff     = 1'b0;
    bus.pwm_A_in      = 1'b0;  bus8.pwm_A_in      = 1'b0;
    bus.pwm_B_in      = 1'b0;  bus8.pwm_B_in      = 1'b0;
    bus.timeout_limit = '0;    bus8.timeout_limit = '0;
    bus.clear_flags   = 1'b0;  bus8.clear_flags   = 1'b0;

    repeat (4) @(negedge clk);
    check("rst_period_A", bus.period_A, 0);
    check("rst_dtime_AB", bus.dtime_AB, 0);
    check("rst_meas_valid", bus.meas_valid, 0);
    check("rst_interrupt", bus.interrupt, 0);
    check("rst_overlap", bus.overlap_err, 0);
    check("rst_timeout", bus.timeout_err, 0);

    // Nominal pair, interrupts disabled: first edge only arms.
    reset = 1'b0;
    bus.capture_onoff = 1'b1;
    repeat (10) @(negedge clk);
    drive(0, 2000, 500, 510, 1480, 0, 2000);
    check("arm_only_no_meas", mv_cnt, 0);
    drive(0, 2000, 500, 510, 1480, 0, 4000);
    check("first_meas_count", mv_cnt, 2);
    check("first_meas_latency", first_mv_delta, 3);
    check("int_off_no_irq", int_cnt, 0);
    check_caps("nom", 2000, 500, 1480, 10, 10);

    // Same pair with interrupts enabled.
    bus.int_onoff = 1'b1;
    drive(0, 2000, 500, 510, 1480, 0, 6000);
    check("nom_meas_count", mv_cnt, 5);
    check("nom_irq_count", int_cnt, 3);
    check_caps("nom2", 2000, 500, 1480, 10, 10);
    check("nom_overlap", bus.overlap_err, 0);
    check("nom_timeout", bus.timeout_err, 0);
    check("hold_meas_valid", bus.meas_valid, 0);
    check("hold_period_A", bus.period_A, 2000);

    // Five cycles of A/B overlap.
    drive(0, 2000, 500, 495, 1500, 0, 4000);
    check_caps("ovl", 2000, 500, 1500, 0, 5);
    check("ovl_flag_set", bus.overlap_err, 1);
    @(negedge clk); bus.clear_flags = 1'b1;
    @(negedge clk); bus.clear_flags = 1'b0;
    check("ovl_flag_cleared", bus.overlap_err, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.pwm_A_in = 1'b1;
      bus.pwm_B_in = 1'b1;
      bus.clear_flags = (i == 8);
      if (i == 7) check("ovl_flag_reset_by_new", bus.overlap_err, 1);
      if (i == 9) check("ovl_set_beats_clear", bus.overlap_err, 1);
    end
    @(negedge clk);
    bus.pwm_A_in = 1'b0;
    bus.pwm_B_in = 1'b0;
    bus.clear_flags = 1'b0;
    repeat (5) @(negedge clk);

    // Loss of signal with a 3000-cycle limit.
    bus.timeout_limit = 16'd3000;
    drive(0, 1000, 400, 410, 580, 0, 2000);
    check_caps("pre_to", 1000, 400, 580, 10, 10);
    mv0 = mv_cnt;
    int0 = int_cnt;
    found = 1'b0;
    for (int n = 0; n < 4000 && !found; n++) begin
      @(negedge clk);
      if (bus.timeout_err === 1'b1) found = 1'b1;
    end
    check("timeout_seen", found, 1);
    check("timeout_delay", cyc - last_rise_cyc, 3003);
    repeat (3100) @(negedge clk);
    check("timeout_irq_once", int_cnt - int0, 1);
    check("timeout_no_meas", mv_cnt - mv0, 0);
    check("timeout_sticky", bus.timeout_err, 1);
    check("timeout_hold_period", bus.period_A, 1000);
    drive(0, 1000, 300, 310, 680, 0, 2000);
    check("restart_meas_count", mv_cnt - mv0, 1);
    check_caps("restart", 1000, 300, 680, 10, 10);

    // Capture disabled mid-period, then re-enabled while A is high.
    bus.timeout_limit = '0;
    drive(0, 2000, 500, 510, 1480, 0, 2200);
    bus.capture_onoff = 1'b0;
    drive(0, 2000, 500, 510, 1480, 200, 30);
    check("off_period_A", bus.period_A, 0);
    check("off_high_A", bus.high_A, 0);
    check("off_high_B", bus.high_B, 0);
    check("off_dtime_AB", bus.dtime_AB, 0);
    check("off_dtime_BA", bus.dtime_BA, 0);
    check("off_meas_valid", bus.meas_valid, 0);
    check("off_interrupt", bus.interrupt, 0);
    check("off_overlap_kept", bus.overlap_err, 1);
    check("off_timeout_kept", bus.timeout_err, 1);
    bus.capture_onoff = 1'b1;
    mv0 = mv_cnt;
    drive(0, 2000, 500, 510, 1480, 230, 1770 + 4000);
    check("rearm_meas_count", mv_cnt - mv0, 1);
    check_caps("rearm", 2000, 500, 1480, 10, 10);

    // Saturation on the 8-bit instance: 300-cycle period, A high 280.
    bus8.capture_onoff = 1'b1;
    repeat (5) @(negedge clk);
    drive(1, 300, 280, 285, 10, 0, 900);
    check("sat_period_A", bus8.period_A, 8'hFF);
    check("sat_high_A", bus8.high_A, 8'hFF);
    check("sat_high_B", bus8.high_B, 10);
    check("sat_dtime_AB", bus8.dtime_AB, 5);
    check("sat_dtime_BA", bus8.dtime_BA, 5);
    check("sat_no_timeout", bus8.timeout_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
